// File: rtl/retire_pkg.sv
// Shared width helpers and per-slot commit record for the retirement stage.
package retire_pkg;

    localparam int MAX_ID_W = 16;

    function automatic int id_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int pr_w(input int phys_regs);
        return $clog2(phys_regs);
    endfunction

    function automatic int br_w(input int branch_depth);
        return $clog2(branch_depth);
    endfunction

    function automatic int cnt_w(input int commit_width);
        return $clog2(commit_width + 1);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic                uses_rw;
        logic                is_load;
        logic                is_store;
        logic                is_branch;
    } commit_slot_t;

endpackage

// File: rtl/retire_prefix_sel.sv
// Contiguous retire mask: stops at the first ineligible slot, at a second
// store in the same cycle, or at any store while the store buffer stalls.
module retire_prefix_sel #(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [COMMIT_WIDTH-1:0] elig_i,
    input  logic [COMMIT_WIDTH-1:0] is_store_i,
    input  logic                    store_stall_i,
    output logic [COMMIT_WIDTH-1:0] retire_o
);

    logic run;
    logic store_seen;

    always_comb begin
        retire_o   = '0;
        run        = 1'b1;
        store_seen = 1'b0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (run && elig_i[k] && !(is_store_i[k] && (store_seen || store_stall_i))) begin
                retire_o[k] = 1'b1;
                if (is_store_i[k]) begin
                    store_seen = 1'b1;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// In-order multi-slot retirement from the active-list head, with writeback
// bypass, store back-pressure, squash recovery and reclaim compaction.
module retire_unit
    import retire_pkg::*;
#(
    parameter  int DEPTH        = 32,
    parameter  int PHYS_REGS    = 64,
    parameter  int COMMIT_WIDTH = 2,
    parameter  int WB_PORTS     = 2,
    parameter  int BRANCH_DEPTH = 8,
    localparam int ID_W         = id_w(DEPTH),
    localparam int PR_W         = pr_w(PHYS_REGS),
    localparam int BR_W         = br_w(BRANCH_DEPTH),
    localparam int CNT_W        = cnt_w(COMMIT_WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WB_PORTS-1:0]                 wb_valid,
    input  logic [WB_PORTS-1:0][ID_W-1:0]       wb_id,
    input  logic [COMMIT_WIDTH-1:0]             alloc_valid,
    input  logic [COMMIT_WIDTH-1:0][ID_W-1:0]   alloc_id,
    input  logic                                squash_valid,
    input  logic [DEPTH-1:0]                    squash_mask,
    input  logic                                store_stall,
    input  logic [DEPTH-1:0]                    al_uses_rw,
    input  logic [DEPTH-1:0]                    al_is_load,
    input  logic [DEPTH-1:0]                    al_is_store,
    input  logic [DEPTH-1:0]                    al_is_branch,
    input  logic [DEPTH-1:0][PR_W-1:0]          al_reclaim_reg,
    output logic [COMMIT_WIDTH-1:0]             commit_valid,
    output logic [COMMIT_WIDTH-1:0][ID_W-1:0]   commit_id,
    output logic [COMMIT_WIDTH-1:0]             reclaim_valid,
    output logic [COMMIT_WIDTH-1:0][PR_W-1:0]   reclaim_reg,
    output logic [CNT_W-1:0]                    load_done_cnt,
    output logic [CNT_W-1:0]                    branch_done_cnt,
    output logic                                store_done,
    output logic [ID_W-1:0]                     oldest_ptr,
    output logic [PR_W-1:0]                     free_tail_ptr,
    output logic [BR_W-1:0]                     branch_rd_ptr,
    output logic [DEPTH-1:0]                    entry_free
);

    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] free_q, free_d;
    logic [ID_W-1:0]  oldest_q, oldest_d;
    logic [PR_W-1:0]  free_tail_q, free_tail_d;
    logic [BR_W-1:0]  br_rd_q, br_rd_d;

    logic [COMMIT_WIDTH-1:0][ID_W-1:0] idx_s;
    logic [COMMIT_WIDTH-1:0]           wb_hit;
    logic [COMMIT_WIDTH-1:0]           elig;
    logic [COMMIT_WIDTH-1:0]           slot_st;
    logic [COMMIT_WIDTH-1:0]           retire_mask;
    commit_slot_t [COMMIT_WIDTH-1:0]   slot;
    logic [CNT_W-1:0]                  ret_cnt;
    logic [CNT_W-1:0]                  rcl_cnt;
    logic                              unused_slot_bits;

    // Writeback this cycle counts as ready so it can retire immediately.
    always_comb begin
        idx_s   = '0;
        wb_hit  = '0;
        elig    = '0;
        slot_st = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            idx_s[k] = oldest_q + ID_W'(k);
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_id[p] == idx_s[k])) begin
                    wb_hit[k] = 1'b1;
                end
            end
            slot_st[k] = al_is_store[idx_s[k]];
            elig[k]    = rst_n && !squash_valid && !free_q[idx_s[k]]
                         && (ready_q[idx_s[k]] || wb_hit[k]);
        end
    end

    retire_prefix_sel #(
        .COMMIT_WIDTH(COMMIT_WIDTH)
    ) u_prefix (
        .elig_i       (elig),
        .is_store_i   (slot_st),
        .store_stall_i(store_stall),
        .retire_o     (retire_mask)
    );

    // Reclaimed registers are packed into the lowest reclaim slots.
    always_comb begin
        slot            = '0;
        commit_valid    = '0;
        commit_id       = '0;
        reclaim_valid   = '0;
        reclaim_reg     = '0;
        load_done_cnt   = '0;
        branch_done_cnt = '0;
        store_done      = 1'b0;
        ret_cnt         = '0;
        rcl_cnt         = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            slot[k].valid     = retire_mask[k];
            slot[k].id        = MAX_ID_W'(idx_s[k]);
            slot[k].uses_rw   = al_uses_rw[idx_s[k]];
            slot[k].is_load   = al_is_load[idx_s[k]];
            slot[k].is_store  = al_is_store[idx_s[k]];
            slot[k].is_branch = al_is_branch[idx_s[k]];
            commit_valid[k]   = slot[k].valid;
            commit_id[k]      = rst_n ? idx_s[k] : '0;
            if (slot[k].valid) begin
                ret_cnt = ret_cnt + CNT_W'(1);
                if (slot[k].uses_rw) begin
                    reclaim_valid[rcl_cnt] = 1'b1;
                    reclaim_reg[rcl_cnt]   = al_reclaim_reg[idx_s[k]];
                    rcl_cnt                = rcl_cnt + CNT_W'(1);
                end
                if (slot[k].is_load) begin
                    load_done_cnt = load_done_cnt + CNT_W'(1);
                end
                if (slot[k].is_branch) begin
                    branch_done_cnt = branch_done_cnt + CNT_W'(1);
                end
                if (slot[k].is_store) begin
                    store_done = 1'b1;
                end
            end
        end
    end

    always_comb begin
        unused_slot_bits = ^slot;
    end

    // Updates applied lowest priority first: alloc, writeback, retire, squash.
    always_comb begin
        ready_d = ready_q;
        free_d  = free_q;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (alloc_valid[k]) begin
                free_d[alloc_id[k]]  = 1'b0;
                ready_d[alloc_id[k]] = 1'b0;
            end
        end
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
                ready_d[wb_id[p]] = 1'b1;
            end
        end
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k]) begin
                free_d[idx_s[k]]  = 1'b1;
                ready_d[idx_s[k]] = 1'b0;
            end
        end
        if (squash_valid) begin
            free_d  = free_d | squash_mask;
            ready_d = ready_d & ~squash_mask;
        end
        oldest_d    = oldest_q + ID_W'(ret_cnt);
        free_tail_d = free_tail_q + PR_W'(rcl_cnt);
        br_rd_d     = br_rd_q + BR_W'(branch_done_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q     <= '0;
            free_q      <= '1;
            oldest_q    <= '0;
            free_tail_q <= '0;
            br_rd_q     <= '0;
        end else begin
            ready_q     <= ready_d;
            free_q      <= free_d;
            oldest_q    <= oldest_d;
            free_tail_q <= free_tail_d;
            br_rd_q     <= br_rd_d;
        end
    end

    always_comb begin
        oldest_ptr    = oldest_q;
        free_tail_ptr = free_tail_q;
        branch_rd_ptr = br_rd_q;
        entry_free    = free_q;
    end

endmodule
